// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a 1W1R SRAM macro with a 2-entry registered output buffer.
// Latency: push at edge N -> read issued at N+1 -> pop_valid after N+2; 1 word/cycle steady.
// Backpressure: push_ready low when the macro holds RAM_DEPTH words; pops throttled by pop_ready.
module sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic       push_fire;
  logic       pop_fire;
  logic       read_issue;
  logic [2:0] occ;
  logic [1:0] ob_after_pop;

  // Outputs that come straight from registers.
  assign pop_valid   = (ob_cnt_q != 2'd0);
  assign pop_data    = ob0_q;
  assign init_done   = (state_q == S_RUN);
  assign sram_wmask0 = '1;
  assign level       = mem_cnt_q + (ADDR_WIDTH+1)'(inflight_q) + (ADDR_WIDTH+1)'(ob_cnt_q);

  // Next-state, macro command and handshake decode.
  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    inflight_d   = 1'b0;
    ob_cnt_d     = ob_cnt_q;
    ob0_d        = ob0_q;
    ob1_d        = ob1_q;
    push_ready   = 1'b0;
    push_fire    = 1'b0;
    pop_fire     = 1'b0;
    read_issue   = 1'b0;
    occ          = 3'd0;
    ob_after_pop = ob_cnt_q;
    sram_csb0    = 1'b1;
    sram_addr0   = wr_ptr_q;
    sram_din0    = push_data;
    sram_csb1    = 1'b1;
    sram_addr1   = rd_ptr_q;

    if (state_q == S_INIT) begin
      sram_csb0   = 1'b0;
      sram_addr0  = init_addr_q;
      sram_din0   = '0;
      init_addr_d = init_addr_q + ADDR_WIDTH'(1);
      if (&init_addr_q) begin
        state_d = S_RUN;
      end
    end else begin
      push_ready = (mem_cnt_q != FULL_CNT);
      if (flush) begin
        // Discard everything, including a read whose data returns next edge.
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        mem_cnt_d  = '0;
        inflight_d = 1'b0;
        ob_cnt_d   = 2'd0;
      end else begin
        push_fire  = push_valid & push_ready;
        pop_fire   = pop_valid & pop_ready;
        // Slots the output side will occupy after this edge, before any new read.
        occ        = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_fire};
        read_issue = (mem_cnt_q != '0) && (occ < 3'd2);

        if (push_fire) begin
          sram_csb0 = 1'b0;
          wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (read_issue) begin
          sram_csb1 = 1'b0;
          rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
        end
        mem_cnt_d  = mem_cnt_q + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(read_issue);
        inflight_d = read_issue;

        // Pop shifts the head out; a returning read lands in the first free slot.
        ob_after_pop = ob_cnt_q - {1'b0, pop_fire};
        if (pop_fire) begin
          ob0_d = ob1_q;
        end
        if (inflight_q) begin
          if (ob_after_pop == 2'd0) begin
            ob0_d = sram_dout1;
          end else begin
            ob1_d = sram_dout1;
          end
          ob_cnt_d = ob_after_pop + 2'd1;
        end else begin
          ob_cnt_d = ob_after_pop;
        end
      end
    end

    // Keep the macro idle and refuse pushes while reset is held.
    if (rst) begin
      sram_csb0  = 1'b1;
      sram_csb1  = 1'b1;
      push_ready = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q     <= INIT_ZERO ? S_INIT : S_RUN;
      init_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      ob_cnt_q    <= 2'd0;
      ob0_q       <= '0;
      ob1_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      inflight_q  <= inflight_d;
      ob_cnt_q    <= ob_cnt_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural 1W1R SRAM model.
// Latency: checks the 2-edge push-to-pop path and 1 word/cycle streaming.
// Backpressure: exercises full, random pop_ready, flush and mid-stream reset.
module tb_sram_fifo_ctrl;
  localparam int AW    = 7;
  localparam int DW    = 4;
  localparam int NW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk0 = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [AW:0]   level;
  logic          init_done;
  logic          sram_csb0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] expq[$];

  always #5 clk0 = ~clk0;

  sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .INIT_ZERO(1'b1)) dut (
    .clk0(clk0), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .level(level), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // SRAM model: sample at posedge, commit write and drive read data at negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [AW-1:0] w_a, r_a;
  logic [DW-1:0] w_d;
  int            wr_cnt = 0;
  int            hazard_hits = 0;

  always @(posedge clk0) begin
    w_en <= !sram_csb0 && (sram_wmask0 == '1);
    w_a  <= sram_addr0;
    w_d  <= sram_din0;
    r_en <= !sram_csb1;
    r_a  <= sram_addr1;
  end

  always @(negedge clk0) begin
    if (w_en) begin
      mem[w_a] = w_d;
      wr_cnt   = wr_cnt + 1;
    end
    if (r_en) sram_dout1 = mem[r_a];
    if (!rst && !sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)) begin
      hazard_hits = hazard_hits + 1;
      if (hazard_hits < 5) $display("FAIL hazard addr0=%0h addr1=%0h both selected", sram_addr0, sram_addr1);
    end
  end

  // Advance one cycle; report pre-edge handshakes and record accepted pushes.
  task automatic step(output bit pf, output bit qf, output logic [DW-1:0] got);
    pf  = push_valid && push_ready;
    qf  = pop_valid && pop_ready;
    got = pop_data;
    if (pf && !flush && !rst) expq.push_back(push_data);
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    int n;
    int nonzero;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'((i % 15) + 1);
    rst = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL rst_push_ready got=%b exp=0", push_ready); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got=%b exp=0", pop_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL rst_pop_data got=%0h exp=0", pop_data); end
    checks++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin errors++; $display("FAIL rst_csb got=%b%b exp=11", sram_csb0, sram_csb1); end
    rst = 1'b0;
    wr_cnt = 0;
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      @(posedge clk0); #1; n++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_cycles got=%0d exp=%0d", n, DEPTH); end
    @(negedge clk0); #1;
    checks++; if (wr_cnt != DEPTH) begin errors++; $display("FAIL init_writes got=%0d exp=%0d", wr_cnt, DEPTH); end
    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nonzero++;
    checks++; if (nonzero != 0) begin errors++; $display("FAIL init_zero nonzero_words=%0d exp=0", nonzero); end
    @(posedge clk0); #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL init_push_ready got=%b exp=1", push_ready); end
    checks++; if (pop_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL init_idle pop_valid=%b level=%0d exp 0/0", pop_valid, level); end
    checks++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin errors++; $display("FAIL idle_csb got=%b%b exp=11", sram_csb0, sram_csb1); end
  endtask

  task automatic test_single();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    push_valid = 1'b1; push_data = 4'h5; pop_ready = 1'b0;
    step(pf, qf, got);
    push_valid = 1'b0;
    checks++; if (pf !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", pf); end
    checks++; if (pop_valid !== 1'b0 || level !== 8'd1) begin errors++; $display("FAIL single_n0 pop_valid=%b level=%0d exp 0/1", pop_valid, level); end
    step(pf, qf, got);
    checks++; if (pop_valid !== 1'b0 || level !== 8'd1) begin errors++; $display("FAIL single_n1 pop_valid=%b level=%0d exp 0/1", pop_valid, level); end
    step(pf, qf, got);
    checks++; if (pop_valid !== 1'b1 || pop_data !== 4'h5 || level !== 8'd1) begin
      errors++; $display("FAIL single_n2 pop_valid=%b data=%0h level=%0d exp 1/5/1", pop_valid, pop_data, level);
    end
    pop_ready = 1'b1;
    step(pf, qf, got);
    pop_ready = 1'b0;
    exp = (expq.size() != 0) ? expq.pop_front() : 'x;
    checks++; if (!qf || got !== exp) begin errors++; $display("FAIL single_pop fire=%b got=%0h exp=%0h", qf, got, exp); end
    checks++; if (level !== '0) begin errors++; $display("FAIL single_level_after got=%0d exp=0", level); end
  endtask

  task automatic test_fill();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    int accepts, extra, pops, n;
    accepts = 0; n = 0; pop_ready = 1'b0; push_valid = 1'b1;
    while (accepts < DEPTH + 2 && n < 1000) begin
      push_data = DW'(accepts % 16);
      step(pf, qf, got);
      if (pf) accepts++;
      n++;
    end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_full push_ready=%b exp=0", push_ready); end
    checks++; if (level !== 8'(DEPTH + 2)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, DEPTH + 2); end
    extra = 0;
    repeat (5) begin
      step(pf, qf, got);
      if (pf) extra++;
    end
    push_valid = 1'b0;
    checks++; if (extra != 0) begin errors++; $display("FAIL fill_overrun extra_accepts=%0d exp=0", extra); end
    pop_ready = 1'b1; pops = 0; n = 0;
    while (expq.size() != 0 && n < 1000) begin
      step(pf, qf, got);
      if (qf) begin
        exp = expq.pop_front();
        pops++;
        checks++; if (got !== exp) begin errors++; $display("FAIL fill_data pop=%0d got=%0h exp=%0h", pops, got, exp); end
      end
      n++;
    end
    pop_ready = 1'b0;
    checks++; if (pops != DEPTH + 2) begin errors++; $display("FAIL fill_pops got=%0d exp=%0d", pops, DEPTH + 2); end
    checks++; if (level !== '0 || pop_valid !== 1'b0) begin errors++; $display("FAIL fill_drained level=%0d pop_valid=%b exp 0/0", level, pop_valid); end
  endtask

  task automatic test_stream();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    int sent, popped, gaps, first, k, bad;
    sent = 0; popped = 0; gaps = 0; first = -1; k = 0; bad = 0;
    pop_ready = 1'b1;
    while (popped < 300 && k < 1000) begin
      push_valid = (sent < 300);
      push_data  = DW'((sent * 7 + 3) % 16);
      step(pf, qf, got);
      if (pf) sent++;
      if (qf) begin
        if (first < 0) first = k;
        exp = (expq.size() != 0) ? expq.pop_front() : 'x;
        popped++;
        if (got !== exp) begin bad++; $display("FAIL stream_data pop=%0d got=%0h exp=%0h", popped, got, exp); end
      end else if (popped > 0) begin
        gaps++;
      end
      k++;
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_data_total bad=%0d exp=0", bad); end
    checks++; if (first != 3) begin errors++; $display("FAIL stream_first_pop step=%0d exp=3", first); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    checks++; if (popped != 300 || k != 303) begin errors++; $display("FAIL stream_rate pops=%0d cycles=%0d exp 300/303", popped, k); end
  endtask

  task automatic test_random();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    int bad, n;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      push_valid = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 30));
      push_data  = DW'($urandom);
      pop_ready  = $urandom_range(0, 1) == 1;
      step(pf, qf, got);
      if (qf) begin
        exp = (expq.size() != 0) ? expq.pop_front() : 'x;
        if (got !== exp) begin bad++; if (bad < 5) $display("FAIL random_data got=%0h exp=%0h", got, exp); end
      end
    end
    push_valid = 1'b0; pop_ready = 1'b1; n = 0;
    while (expq.size() != 0 && n < 1000) begin
      step(pf, qf, got);
      if (qf) begin
        exp = expq.pop_front();
        if (got !== exp) begin bad++; if (bad < 5) $display("FAIL random_drain got=%0h exp=%0h", got, exp); end
      end
      n++;
    end
    pop_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL random_scoreboard bad=%0d exp=0", bad); end
    checks++; if (level !== '0 || expq.size() != 0) begin errors++; $display("FAIL random_empty level=%0d left=%0d exp 0/0", level, expq.size()); end
    checks++; if (hazard_hits != 0) begin errors++; $display("FAIL hazard_total got=%0d exp=0", hazard_hits); end
  endtask

  task automatic test_flush();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    int n, seen;
    pop_ready = 1'b0; n = 0;
    for (int i = 0; i < 11; i++) begin
      push_valid = 1'b1; push_data = DW'(i + 2);
      step(pf, qf, got);
    end
    push_valid = 1'b0;
    repeat (3) step(pf, qf, got);
    checks++; if (level !== 8'd11) begin errors++; $display("FAIL flush_pre_level got=%0d exp=11", level); end
    pop_ready = 1'b1;
    step(pf, qf, got);
    pop_ready = 1'b0;
    exp = (expq.size() != 0) ? expq.pop_front() : 'x;
    checks++; if (!qf || got !== exp) begin errors++; $display("FAIL flush_pre_pop fire=%b got=%0h exp=%0h", qf, got, exp); end
    checks++; if (level !== 8'd10) begin errors++; $display("FAIL flush_inflight_level got=%0d exp=10", level); end
    flush = 1'b1; push_valid = 1'b1; push_data = 4'h7; pop_ready = 1'b1;
    @(posedge clk0); #1;
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    expq.delete();
    checks++; if (level !== '0 || pop_valid !== 1'b0) begin errors++; $display("FAIL flush_clear level=%0d pop_valid=%b exp 0/0", level, pop_valid); end
    seen = 0;
    repeat (3) begin
      step(pf, qf, got);
      if (pop_valid || level != 0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_stale cycles_nonempty=%0d exp=0", seen); end
    push_valid = 1'b1; push_data = 4'hA;
    step(pf, qf, got);
    push_valid = 1'b0; pop_ready = 1'b1;
    qf = 1'b0;
    while (!qf && n < 10) begin step(pf, qf, got); n++; end
    pop_ready = 1'b0;
    exp = (expq.size() != 0) ? expq.pop_front() : 'x;
    checks++; if (!qf || got !== exp) begin errors++; $display("FAIL flush_after_push fire=%b got=%0h exp=%0h", qf, got, exp); end
  endtask

  task automatic test_midreset();
    bit pf, qf;
    logic [DW-1:0] got, exp;
    int n;
    push_valid = 1'b1; pop_ready = 1'b1;
    repeat (20) begin push_data = DW'($urandom); step(pf, qf, got); end
    rst = 1'b1;
    @(posedge clk0); #1;
    checks++; if (level !== '0 || push_ready !== 1'b0 || pop_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL midrst_state level=%0d push_ready=%b pop_valid=%b init_done=%b exp 0/0/0/0", level, push_ready, pop_valid, init_done);
    end
    rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    expq.delete();
    wr_cnt = 0; n = 0;
    while (init_done !== 1'b1 && n < 300) begin @(posedge clk0); #1; n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL midrst_init_cycles got=%0d exp=%0d", n, DEPTH); end
    checks++; if (wr_cnt < DEPTH - 1 || wr_cnt > DEPTH) begin errors++; $display("FAIL midrst_init_writes got=%0d exp=%0d", wr_cnt, DEPTH); end
    push_valid = 1'b1; push_data = 4'h3;
    step(pf, qf, got);
    push_valid = 1'b0; pop_ready = 1'b1; n = 0; qf = 1'b0;
    while (!qf && n < 10) begin step(pf, qf, got); n++; end
    pop_ready = 1'b0;
    exp = (expq.size() != 0) ? expq.pop_front() : 'x;
    checks++; if (!qf || got !== exp) begin errors++; $display("FAIL midrst_pop fire=%b got=%0h exp=%0h", qf, got, exp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_flush();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives one 1W1R OpenRAM macro (default 128x4) as FIFO storage.
- Push side: valid/ready. Pop side: valid/ready backed by a 2-entry output buffer, which hides the macro's 1-cycle read latency and sustains 1 word/cycle.
- After reset, an init state machine zero-fills the macro. Sits between a streaming producer/consumer pair and the SRAM instance.

Parameters:
- ADDR_WIDTH, 7, macro address width; RAM_DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, 4, word width.
- NUM_WMASKS, 4, macro write-mask width; always driven all-ones.
- INIT_ZERO, 1, 1 = zero-fill the macro after reset; 0 = skip straight to RUN.

Ports:
- clk0  in  1  clock; also drives the macro clk0/clk1.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous discard of all contents; no re-init.
- push_valid  in  1  producer has a word.
- push_ready  out  1  controller can accept a word.
- push_data  in  DATA_WIDTH  write word.
- pop_valid  out  1  head word is present on pop_data.
- pop_ready  in  1  consumer takes the head word.
- pop_data  out  DATA_WIDTH  head word.
- level  out  ADDR_WIDTH+1  total words held: memory + in-flight read + output buffer.
- init_done  out  1  high in RUN.
- sram_csb0  out  1  macro write chip select, active-low.
- sram_wmask0  out  NUM_WMASKS  macro write mask.
- sram_addr0  out  ADDR_WIDTH  macro write address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_csb1  out  1  macro read chip select, active-low.
- sram_addr1  out  ADDR_WIDTH  macro read address.
- sram_dout1  in  DATA_WIDTH  macro read data.

Behaviour:
- Macro timing contract:
  - The macro samples csb/addr/din at the posedge.
  - Writes commit at the following negedge.
  - Read data is valid from that negedge to the next posedge.
  - Hence a read issued at edge N is captured by this block at edge N+1.
- Reset (rst=1 at an edge), next-state values:
  - state=INIT (RUN if INIT_ZERO=0); wr_ptr=rd_ptr=0; mem_cnt=0; inflight=0; outbuf empty.
  - Outputs: push_ready=0, pop_valid=0, level=0, init_done=0, sram_csb0=1, sram_csb1=1, pop_data=0.
  - rst overrides flush and all handshakes; an in-flight read is dropped.
- FSM INIT:
  - init_addr counts 0..RAM_DEPTH-1, one write per cycle: csb0=0, addr0=init_addr, din0=0, wmask0=all-ones.
  - push_ready=0, pop_valid=0, csb1=1.
  - After address RAM_DEPTH-1 is written, go to RUN. Duration is exactly RAM_DEPTH cycles.
  - flush is ignored in INIT.
- FSM RUN:
  - push_ready = (mem_cnt != RAM_DEPTH).
  - Push accepted when push_valid & push_ready: csb0=0, addr0=wr_ptr, din0=push_data; wr_ptr+1 mod RAM_DEPTH.
  - Read issue condition: mem_cnt>0 && (outbuf_cnt + inflight − pop_fire) < 2.
  - On issue: csb1=0, addr1=rd_ptr; rd_ptr+1; inflight=1 next cycle.
  - mem_cnt next = mem_cnt + push_fire − read_issue (both in the same cycle is legal).
  - inflight=1: sram_dout1 is written into the outbuf tail at the edge.
  - pop_fire = pop_valid & pop_ready removes the outbuf head.
  - Capture and pop in the same cycle are both honoured.
  - pop_data/pop_valid come from registers only; no combinational path from push_data.
  - level = mem_cnt + inflight + outbuf_cnt. Maximum is RAM_DEPTH+2, which fits in ADDR_WIDTH+1 bits.
- Hazard rule:
  - Read and write are never issued to the same address in one cycle.
  - This is guaranteed because reads require mem_cnt>0 (committed words only) and pushes are blocked at mem_cnt=RAM_DEPTH.
  - Bench asserts csb0|csb1|(addr0!=addr1).
- Latency:
  - Push accepted at edge N into an empty FIFO: read issues at edge N+1, and pop_valid=1 after edge N+2.
  - Steady-state throughput is 1 push and 1 pop per cycle.
- Wrap-around: pointers wrap RAM_DEPTH-1 -> 0 with no bubble.
- flush in RUN:
  - Next state: pointers=0, mem_cnt=0, outbuf empty, inflight cleared (a returning read is discarded).
  - A push or pop coinciding with flush is dropped.
  - Memory contents are not re-zeroed.
- Idle: csb0=1 and csb1=1 whenever no access is issued, to save power.

Test Plan:
- Reset, hold for RAM_DEPTH cycles -> exactly 128 writes of 0 to addresses 0..127; init_done rises on cycle 128; push_ready=1; pop_valid=0; level=0.
- After init, push 0x5 at edge N with pop_ready=0 -> pop_valid=1 with pop_data=0x5 after edge N+2; level=1.
- Push 130 words (i mod 16) with pop_ready=0 -> push_ready drops after 130 accepts; level=130; popping returns 0,1,...,1 (130 words) in order.
- Continuous push and pop with pop_ready=1 for 300 words -> after a 2-cycle fill, one pop per cycle; pointers wrap twice; data is in order with no gaps or duplicates.
- Random pop_ready (50%) with random push_valid -> a scoreboard matches the data; the same-address hazard assertion never fires.
- With level=10 and a read in flight, assert flush -> next cycle level=0 and pop_valid=0; the returning read is dropped; a new push of 0xA pops as 0xA. Asserting rst mid-stream -> init re-runs for 128 cycles.
